fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage: PC register, instruction-memory request handshake and IF/ID pipeline register in one block. It consumes the load-use stall controls (pc_write, ifid_write) produced by the hazard unit and the branch/jump redirect from the downstream decode stage. It delivers {pc+4, instruction, valid} to the decode stage. A variable-latency instruction memory is tolerated through a req/ready handshake and a one-entry hold buffer.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
NOP_INSTR, 32'h00000000, instruction word inserted into IF/ID on bubbles and flushes

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
pc_write  input  1  1 = PC may advance; 0 = load-use stall from hazard unit
ifid_write  input  1  1 = IF/ID may load; 0 = hold IF/ID contents
redirect  input  1  taken branch or jump resolved downstream; flush and retarget
redirect_pc  input  32  new PC when redirect=1; bits [1:0] ignored and treated as 0
imem_req  output  1  fetch request valid
imem_addr  output  32  word-aligned fetch address; equals pc
imem_rdata  input  32  instruction word; valid only when imem_req && imem_ready
imem_ready  input  1  memory accepts and completes the request this cycle
ifid_pc4  output  32  registered PC+4 of the instruction in IF/ID
ifid_instr  output  32  registered instruction
ifid_valid  output  1  IF/ID holds a real instruction
fetch_busy  output  1  1 while in WAIT/DROP with no completion this cycle (debug/perf)

Behaviour:
- Reset (asynchronous, any state): pc=RESET_PC, state=FETCH, ifid_pc4=0, ifid_instr=NOP_INSTR, ifid_valid=0, hold buffer empty. imem_req=1 from the first cycle after reset deasserts.
- "advance" = pc_write && ifid_write. The hazard unit always drives the two together; the unequal case is treated as a stall (no advance).
- States: FETCH (request outstanding), HOLD (instruction received, waiting for advance), DROP (discarding an in-flight fetch after a redirect).
- FETCH: imem_req=1. imem_addr=pc, held stable until imem_ready.
  - imem_ready && advance: IF/ID <= {pc+4, imem_rdata, 1}; pc <= pc+4; stay in FETCH. Throughput is 1 instruction/cycle with a zero-wait memory.
  - imem_ready && !advance: buffer imem_rdata and pc+4; IF/ID unchanged; go to HOLD.
  - !imem_ready && ifid_write: IF/ID <= {ifid_pc4, NOP_INSTR, 0}, a bubble; pc unchanged.
  - !imem_ready && !ifid_write: IF/ID unchanged.
- HOLD: imem_req=0. On advance: IF/ID <= buffered entry with valid=1; pc <= pc+4; go to FETCH. Otherwise hold everything.
- DROP: imem_req=1, address unchanged from the aborted fetch. When imem_ready: discard rdata; pc <= latched redirect target; go to FETCH. Until then, IF/ID shows the bubble.
- The redirect target is latched in a 32-bit register for use in DROP.
- redirect has priority over pc_write, ifid_write and imem_ready:
  - IF/ID <= {0, NOP_INSTR, 0} in the same edge; the hold buffer is cleared.
  - FETCH && !imem_ready: latch target, go to DROP. The memory transaction is never abandoned mid-request.
  - FETCH && imem_ready, or HOLD: pc <= redirect_pc; go to FETCH. Returned data is discarded.
  - DROP: overwrite the latched target; remain in DROP.
- A second redirect in the same cycle as a DROP completion: the new target wins.
- PC arithmetic is modulo 2^32: pc=32'hFFFFFFFC advances to 32'h00000000 with no flag.
- fetch_busy = (state==FETCH || state==DROP) && !imem_ready.
- No combinational path from imem_rdata to any output. imem_req and imem_addr depend only on state and registers.

Test Plan:
1. Zero-wait memory (imem_ready=1), pc_write=ifid_write=1, RESET_PC=0 -> ifid_pc4 = 4, 8, 12 on consecutive cycles with ifid_valid=1 and ifid_instr = memory words 0, 1, 2.
2. Load-use stall: pc_write=ifid_write=0 for 1 cycle at pc=8 -> IF/ID holds pc4=8; the word at 8 is buffered (HOLD, imem_req=0); after release, ifid_pc4=12 with the correct word and no duplicate or lost instruction.
3. Memory with 2 wait cycles -> ifid_valid=0 bubbles with ifid_instr=NOP_INSTR; fetch_busy=1 for exactly 2 cycles per fetch; imem_addr stable during waits.
4. redirect=1, redirect_pc=32'h100, during a wait cycle -> IF/ID flushed the same edge; state DROP; old data discarded on ready; next imem_addr=32'h100.
5. redirect and pc_write=ifid_write=0 in the same cycle -> the flush wins: ifid_valid=0, pc=redirect_pc.
6. rst asserted asynchronously mid-HOLD -> all outputs return to reset values immediately without a clock edge; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction-memory handshake and IF/ID outputs.
`timescale 1ns/1ps
interface fetch_if;
  logic        pc_write;
  logic        ifid_write;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        fetch_busy;

  modport master (
    input  pc_write, ifid_write, redirect, redirect_pc, imem_rdata, imem_ready,
    output imem_req, imem_addr, ifid_pc4, ifid_instr, ifid_valid, fetch_busy
  );

  modport slave (
    output pc_write, ifid_write, redirect, redirect_pc, imem_rdata, imem_ready,
    input  imem_req, imem_addr, ifid_pc4, ifid_instr, ifid_valid, fetch_busy
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem req/ready handshake, one-entry hold buffer and IF/ID register.
// One instruction per cycle on zero-wait memory; stalls buffer a returned word, redirects flush IF/ID same edge.
`timescale 1ns/1ps
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } hold_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] tgt, tgt_nxt;
  hold_t       hold_q, hold_nxt;
  ifid_t       ifid, ifid_nxt;

  logic        advance;
  logic [31:0] pc_inc;
  logic [31:0] redirect_tgt;

  // Unequal pc_write/ifid_write is treated as a stall.
  assign advance      = bus.pc_write && bus.ifid_write;
  assign pc_inc       = pc + 32'd4;
  assign redirect_tgt = bus.redirect_pc & ~32'd3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      tgt    <= 32'd0;
      hold_q <= {32'd0, NOP_INSTR};
      ifid   <= {32'd0, NOP_INSTR, 1'b0};
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      tgt    <= tgt_nxt;
      hold_q <= hold_nxt;
      ifid   <= ifid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    tgt_nxt   = tgt;
    hold_nxt  = hold_q;
    ifid_nxt  = ifid;

    if (bus.redirect) begin
      ifid_nxt = {32'd0, NOP_INSTR, 1'b0};
      hold_nxt = {32'd0, NOP_INSTR};
      case (state)
        FETCH: begin
          // An outstanding request must complete before the new target is fetched.
          if (bus.imem_ready) begin
            pc_nxt    = redirect_tgt;
            state_nxt = FETCH;
          end else begin
            tgt_nxt   = redirect_tgt;
            state_nxt = DROP;
          end
        end
        HOLD: begin
          pc_nxt    = redirect_tgt;
          state_nxt = FETCH;
        end
        DROP: begin
          tgt_nxt   = redirect_tgt;
          state_nxt = DROP;
        end
        default: state_nxt = FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (bus.imem_ready) begin
            if (advance) begin
              ifid_nxt = {pc_inc, bus.imem_rdata, 1'b1};
              pc_nxt   = pc_inc;
            end else begin
              hold_nxt  = {pc_inc, bus.imem_rdata};
              state_nxt = HOLD;
            end
          end else if (bus.ifid_write) begin
            ifid_nxt = {ifid.pc4, NOP_INSTR, 1'b0};
          end
        end
        HOLD: begin
          if (advance) begin
            ifid_nxt  = {hold_q.pc4, hold_q.instr, 1'b1};
            pc_nxt    = pc_inc;
            state_nxt = FETCH;
          end
        end
        DROP: begin
          if (bus.imem_ready) begin
            pc_nxt    = tgt;
            state_nxt = FETCH;
          end
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

  assign bus.imem_req   = (state != HOLD);
  assign bus.imem_addr  = pc;
  assign bus.ifid_pc4   = ifid.pc4;
  assign bus.ifid_instr = ifid.instr;
  assign bus.ifid_valid = ifid.valid;
  assign bus.fetch_busy = ((state == FETCH) || (state == DROP)) && !bus.imem_ready;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, async-reset sequence, then randomized run against a stream model.
`timescale 1ns/1ps
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk;
  logic rst;
  fetch_if bus ();

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instruction memory contents as a pure function of address.
  function automatic logic [31:0] w(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        pw, iw, rd;
    logic [31:0] rpc;
    logic        rdy;
    logic        busy;
    logic        req;
    logic [31:0] addr, pc4, instr;
    logic        valid;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic pw, input logic iw, input logic rd, input logic [31:0] rpc,
                     input logic rdy, input logic busy, input logic req, input logic [31:0] addr,
                     input logic [31:0] pc4, input logic [31:0] instr, input logic valid);
    vec_t v;
    v.pw = pw; v.iw = iw; v.rd = rd; v.rpc = rpc; v.rdy = rdy; v.busy = busy;
    v.req = req; v.addr = addr; v.pc4 = pc4; v.instr = instr; v.valid = valid;
    vt.push_back(v);
  endtask

  task automatic drive(input logic pw, input logic iw, input logic rd, input logic [31:0] rpc,
                       input logic rdy);
    bus.pc_write    = pw;
    bus.ifid_write  = iw;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.imem_ready  = rdy;
    bus.imem_rdata  = rdy ? w(bus.imem_addr) : ($urandom() ^ 32'hBAD0_0000);
  endtask

  logic [31:0] exp_pc, prev_pc4, prev_instr, addr_pre;
  logic        prev_valid, req_pre, adv, rd, rdy;
  logic [31:0] rpc;
  int          delivered;

  initial begin
    rst = 1'b1;
    bus.pc_write = 1'b0; bus.ifid_write = 1'b0; bus.redirect = 1'b0;
    bus.redirect_pc = 32'd0; bus.imem_ready = 1'b0; bus.imem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_pc4",   bus.ifid_pc4,   32'd0);
    check("reset_instr", bus.ifid_instr, NOP);
    check("reset_valid", {31'd0, bus.ifid_valid}, 32'd0);
    check("reset_addr",  bus.imem_addr,  32'd0);
    check("reset_req",   {31'd0, bus.imem_req}, 32'd1);

    // pw iw rd rpc rdy | busy(pre) | req addr pc4 instr valid (post)
    add(H,H,L,32'h0,H, L, H,32'h4,32'h4,w(32'h0),H);
    add(H,H,L,32'h0,H, L, H,32'h8,32'h8,w(32'h4),H);
    add(L,L,L,32'h0,H, L, L,32'h8,32'h8,w(32'h4),H);           // load-use stall buffers word 8
    add(H,H,L,32'h0,L, L, H,32'hC,32'hC,w(32'h8),H);
    add(H,H,L,32'h0,L, H, H,32'hC,32'hC,NOP,L);                // two wait cycles
    add(H,H,L,32'h0,L, H, H,32'hC,32'hC,NOP,L);
    add(H,H,L,32'h0,H, L, H,32'h10,32'h10,w(32'hC),H);
    add(H,H,L,32'h0,L, H, H,32'h10,32'h10,NOP,L);
    add(H,H,H,32'h100,L, H, H,32'h10,32'h0,NOP,L);             // redirect during wait -> DROP
    add(H,H,L,32'h0,L, H, H,32'h10,32'h0,NOP,L);
    add(H,H,L,32'h0,H, L, H,32'h100,32'h0,NOP,L);
    add(H,H,L,32'h0,H, L, H,32'h104,32'h104,w(32'h100),H);
    add(L,L,H,32'h200,H, L, H,32'h200,32'h0,NOP,L);            // redirect beats stall
    add(L,L,L,32'h0,H, L, L,32'h200,32'h0,NOP,L);
    add(L,L,H,32'hFFFF_FFFF,L, L, H,32'hFFFF_FFFC,32'h0,NOP,L); // redirect from HOLD, low bits ignored
    add(H,H,L,32'h0,H, L, H,32'h0,32'h0,w(32'hFFFF_FFFC),H);   // PC wraps
    add(H,H,L,32'h0,H, L, H,32'h4,32'h4,w(32'h0),H);
    add(H,H,H,32'h300,L, H, H,32'h4,32'h0,NOP,L);
    add(H,H,H,32'h400,H, L, H,32'h4,32'h0,NOP,L);              // newer target wins over DROP completion
    add(H,H,L,32'h0,H, L, H,32'h400,32'h0,NOP,L);
    add(H,H,L,32'h0,H, L, H,32'h404,32'h404,w(32'h400),H);

    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].pw, vt[i].iw, vt[i].rd, vt[i].rpc, vt[i].rdy);
      #1;
      check($sformatf("v%0d_busy", i), {31'd0, bus.fetch_busy}, {31'd0, vt[i].busy});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_req", i),   {31'd0, bus.imem_req},   {31'd0, vt[i].req});
      check($sformatf("v%0d_addr", i),  bus.imem_addr,  vt[i].addr);
      check($sformatf("v%0d_pc4", i),   bus.ifid_pc4,   vt[i].pc4);
      check($sformatf("v%0d_instr", i), bus.ifid_instr, vt[i].instr);
      check($sformatf("v%0d_valid", i), {31'd0, bus.ifid_valid}, {31'd0, vt[i].valid});
    end

    // Asynchronous reset while in HOLD.
    @(negedge clk);
    drive(L, L, L, 32'h0, H);
    @(posedge clk);
    #1;
    check("hold_req", {31'd0, bus.imem_req}, 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_pc4",   bus.ifid_pc4,   32'd0);
    check("arst_instr", bus.ifid_instr, NOP);
    check("arst_valid", {31'd0, bus.ifid_valid}, 32'd0);
    check("arst_addr",  bus.imem_addr,  32'd0);
    check("arst_req",   {31'd0, bus.imem_req}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    drive(H, H, L, 32'h0, H);
    #1;
    check("restart_addr", bus.imem_addr, 32'd0);
    @(posedge clk);
    #1;
    check("restart_pc4",   bus.ifid_pc4,   32'd4);
    check("restart_instr", bus.ifid_instr, w(32'h0));
    check("restart_valid", {31'd0, bus.ifid_valid}, 32'd1);

    // Randomized run: valid IF/ID entries must follow program order from the latest redirect.
    exp_pc = 32'd4;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      adv = ($urandom_range(0, 9) < 8);
      rd  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      rpc = $urandom();
      req_pre    = bus.imem_req;
      addr_pre   = bus.imem_addr;
      prev_pc4   = bus.ifid_pc4;
      prev_instr = bus.ifid_instr;
      prev_valid = bus.ifid_valid;
      drive(adv, adv, rd, rpc, rdy);
      #1;
      check("rnd_busy", {31'd0, bus.fetch_busy}, {31'd0, req_pre && !rdy});
      @(posedge clk);
      #1;
      if (req_pre && !rdy) begin
        check("rnd_req_hold",  {31'd0, bus.imem_req}, 32'd1);
        check("rnd_addr_hold", bus.imem_addr, addr_pre);
      end
      if (rd) begin
        check("rnd_flush_pc4",   bus.ifid_pc4,   32'd0);
        check("rnd_flush_instr", bus.ifid_instr, NOP);
        check("rnd_flush_valid", {31'd0, bus.ifid_valid}, 32'd0);
        exp_pc = rpc & ~32'd3;
      end else if (adv) begin
        if (bus.ifid_valid) begin
          check("rnd_pc4",   bus.ifid_pc4,   exp_pc + 32'd4);
          check("rnd_instr", bus.ifid_instr, w(exp_pc));
          exp_pc = exp_pc + 32'd4;
          delivered++;
        end else begin
          check("rnd_bubble_instr", bus.ifid_instr, NOP);
          check("rnd_bubble_pc4",   bus.ifid_pc4,   prev_pc4);
        end
      end else begin
        check("rnd_stall_pc4",   bus.ifid_pc4,   prev_pc4);
        check("rnd_stall_instr", bus.ifid_instr, prev_instr);
        check("rnd_stall_valid", {31'd0, bus.ifid_valid}, {31'd0, prev_valid});
      end
    end
    check("rnd_progress", {31'd0, delivered > 200}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
